// File: rtl/ks_sub8_pipe.sv
// 8-bit subtractor (A + ~B + 1) on a Kogge-Stone prefix network, two-stage valid/ready pipeline.
// Define KS_SUB8_SAT_EN to clamp underflowing results to 0x00 instead of wrapping mod 256.
module ks_sub8_pipe (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_diff,
    output logic       out_borrow,
    output logic       out_zero,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam int DATA_W = 8;

`ifdef KS_SUB8_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] f_sat(input logic [DATA_W-1:0] diff,
                                                 input logic              borrow);
        return (SAT_EN && borrow) ? '0 : diff;
    endfunction

    logic [DATA_W-1:0] r_g_p1;
    logic [DATA_W-1:0] r_p_p1;
    logic              r_vld_p1;
    logic [DATA_W-1:0] r_diff_p2;
    logic              r_borrow_p2;
    logic              r_zero_p2;
    logic              r_vld_p2;

    logic              w_adv_p1;
    logic              w_adv_p2;
    logic              w_accept;
    logic [DATA_W-1:0] w_g0, w_p0, w_g1, w_p1, w_g2, w_p2, w_g3;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic              w_borrow;
    logic              w_zero;

    assign w_adv_p2 = !r_vld_p2 || out_ready;
    assign w_adv_p1 = !r_vld_p1 || w_adv_p2;
    assign in_ready = !rst && w_adv_p1;
    assign w_accept = in_valid && in_ready;

    // Stage 1: bitwise generate/propagate of A + ~B
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_g_p1 <= in_a & ~in_b;
            r_p_p1 <= in_a ^ ~in_b;
        end
    end

    // Carry-in of 1 folds into bit 0 so every group generate already spans the cin.
    assign w_g0 = {r_g_p1[7:1], r_g_p1[0] | r_p_p1[0]};
    assign w_p0 = r_p_p1;

    assign w_g1 = w_g0 | (w_p0 & {w_g0[6:0], 1'b0});
    assign w_p1 = w_p0 & {w_p0[6:0], 1'b0};

    assign w_g2 = w_g1 | (w_p1 & {w_g1[5:0], 2'b0});
    assign w_p2 = w_p1 & {w_p1[5:0], 2'b0};

    assign w_g3 = w_g2 | (w_p2 & {w_g2[3:0], 4'b0});

    assign w_sum    = r_p_p1 ^ {w_g3[6:0], 1'b1};
    assign w_borrow = ~w_g3[7];
    assign w_diff   = f_sat(w_sum, w_borrow);
    assign w_zero   = (w_diff == '0);

    // Stage 2: registered result fields and pipeline occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1    <= 1'b0;
            r_vld_p2    <= 1'b0;
            r_diff_p2   <= '0;
            r_borrow_p2 <= 1'b0;
            r_zero_p2   <= 1'b0;
        end else begin
            if (w_adv_p1) begin
                r_vld_p1 <= w_accept;
            end
            if (w_adv_p2) begin
                r_vld_p2 <= r_vld_p1;
            end
            if (w_adv_p2 && r_vld_p1) begin
                r_diff_p2   <= w_diff;
                r_borrow_p2 <= w_borrow;
                r_zero_p2   <= w_zero;
            end
        end
    end

    assign out_diff   = r_diff_p2;
    assign out_borrow = r_borrow_p2;
    assign out_zero   = r_zero_p2;
    assign out_valid  = r_vld_p2;

endmodule

// File: tb/tb_ks_sub8_pipe.sv
// Bench for ks_sub8_pipe: arithmetic reference model with scoreboard plus directed literal vectors.
module tb_ks_sub8_pipe;

`ifdef KS_SUB8_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_diff;
    logic       out_borrow;
    logic       out_zero;
    logic       out_valid;
    logic       out_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;

    ks_sub8_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_diff  (out_diff),
        .out_borrow(out_borrow),
        .out_zero  (out_zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // {borrow, zero, diff} from plain integer subtraction
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b);
        int         d;
        logic       bo;
        logic [7:0] df;
        d  = int'(a) - int'(b);
        bo = (d < 0);
        df = (SAT && bo) ? 8'h00 : 8'(d & 255);
        return {bo, (df == 8'h00), df};
    endfunction

    logic [9:0]  expq[$];
    bit          held = 1'b0;
    logic [10:0] held_val;

    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            held = 1'b0;
        end else begin
            if (held)
                chk("stable_while_stalled", 32'({out_valid, out_borrow, out_zero, out_diff}),
                    32'(held_val));
            if (out_valid) begin
                chk("result_expected", 32'(expq.size() > 0), 32'd1);
                if (out_ready && expq.size() > 0) begin
                    chk("result", 32'({out_borrow, out_zero, out_diff}), 32'(expq.pop_front()));
                    n_out++;
                end
            end
            held     = out_valid && !out_ready;
            held_val = {out_valid, out_borrow, out_zero, out_diff};
            if (in_valid && in_ready)
                expq.push_back(model(in_a, in_b));
        end
    end

    task automatic dir(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                       input logic eb, input logic ez, input string nm);
        int cnt;
        bit ok;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk({nm, "_accept"}, 32'(ok), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt      = 1;
        while (!out_valid && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk({nm, "_latency"}, 32'(cnt), 32'd2);
        chk({nm, "_diff"}, 32'(out_diff), 32'(ed));
        chk({nm, "_borrow"}, 32'(out_borrow), 32'(eb));
        chk({nm, "_zero"}, 32'(out_zero), 32'(ez));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sa[6];
        logic [7:0] sb[6];
        int         acc;
        int         n0;
        int         lowrdy;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_diff", 32'(out_diff), 32'd0);
        chk("rst_out_borrow", 32'(out_borrow), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // directed vectors with literal expectations
        dir(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, "basic");
`ifdef KS_SUB8_SAT_EN
        dir(8'h10, 8'h20, 8'h00, 1'b1, 1'b1, "underflow");
        dir(8'h00, 8'h01, 8'h00, 1'b1, 1'b1, "zero_minus_one");
`else
        dir(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, "underflow");
        dir(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, "zero_minus_one");
`endif
        dir(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, "ff_minus_ff");
        dir(8'h80, 8'h7F, 8'h01, 1'b0, 1'b0, "80_minus_7f");
        dir(8'h33, 8'h33, 8'h00, 1'b0, 1'b1, "a_eq_b");

        // back-to-back stream
        n0     = n_out;
        lowrdy = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_a     = 8'($urandom);
            in_b     = 8'($urandom);
            in_valid = 1'b1;
            if (!in_ready) lowrdy++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("stream_in_ready_low_cycles", 32'(lowrdy), 32'd0);
        chk("stream_result_count", 32'(n_out - n0), 32'd256);

        // stall with pipeline filling
        sa = '{8'h44, 8'h01, 8'hC0, 8'h7E, 8'h00, 8'h00};
        sb = '{8'h11, 8'h02, 8'h3F, 8'h7E, 8'h00, 8'h00};
        n0  = n_out;
        acc = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_a     = sa[acc];
            in_b     = sb[acc];
            in_valid = 1'b1;
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        chk("stall_accepted", 32'(acc), 32'd2);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_no_transfer", 32'(n_out - n0), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        for (int c = 0; c < 6 && acc < 4; c++) begin
            in_a     = sa[acc];
            in_b     = sb[acc];
            in_valid = 1'b1;
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("release_result_count", 32'(n_out - n0), 32'd4);

        // random handshake pressure
        for (int i = 0; i < 300; i++) begin
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("random_drained", 32'(expq.size()), 32'd0);

        // reset with both stages full
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_a     = 8'(8'h90 + c);
            in_b     = 8'(8'h10 + c);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_cycle_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_diff", 32'(out_diff), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("after_rst_in_ready", 32'(in_ready), 32'd1);
        n0 = n_out;
        repeat (5) @(posedge clk);
        #1;
        chk("no_stale_results", 32'(n_out - n0), 32'd0);
        chk("no_stale_valid", 32'(out_valid), 32'd0);

        dir(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, "post_reset_basic");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ks_sub8_pipe.md
KS_SUB8_PIPE -- requirements
Module: ks_sub8_pipe

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have port in_a, input, 8, minuend A (unsigned).
REQ-004 SHALL have port in_b, input, 8, subtrahend B (unsigned).
REQ-005 SHALL have port in_valid, input, 1, A/B pair offered this cycle.
REQ-006 SHALL have port in_ready, output, 1, block accepts pair this cycle.
REQ-007 SHALL have port out_diff, output, 8, result A-B mod 256 (or clamped, see Configuration).
REQ-008 SHALL have port out_borrow, output, 1, 1 when A<B.
REQ-009 SHALL have port out_zero, output, 1, 1 when out_diff==0x00.
REQ-010 SHALL have port out_valid, output, 1, result fields valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts result this cycle.

Function
REQ-012 SHALL compute A-B as A + ~B + 1 using an 8-bit Kogge-Stone parallel-prefix carry network (bitwise G/P, three prefix levels, sum XOR), no ripple chain.
REQ-013 SHALL define out_borrow as the inverse of the prefix-network carry out of bit 7.
REQ-014 SHALL be a 2-stage pipeline: S1 registers bitwise G=A&~B, P=A^~B with cin=1; S2 registers prefix result, diff, borrow, zero.
REQ-015 SHALL give latency of exactly 2 cycles from accepted input (in_valid&&in_ready at edge N) to out_valid at edge N+2 when out_ready held high.
REQ-016 SHALL sustain throughput of one result per cycle while out_ready is high.
REQ-017 SHALL advance S2 when S2 is empty or out_ready=1; S1 advances when S1 is empty or S2 advances.
REQ-018 SHALL drive in_ready = !S1_valid || S2 advancing; combinational from out_ready permitted, no combinational path from in_valid to in_ready.
REQ-019 SHALL hold out_diff, out_borrow, out_zero, out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL transfer a result only on out_valid&&out_ready; no result dropped or duplicated under any stall pattern.
REQ-021 SHALL keep the pipeline full (both stages valid, in_ready=0) when stalled with two results pending; no further acceptance until out_ready=1.
REQ-022 SHALL, on a simultaneous output transfer and input acceptance, retire the S2 result and move S1 and the new pair forward in the same edge.
REQ-023 SHALL produce 0x00 with out_borrow=0, out_zero=1 for A==B.

Reset
REQ-024 SHALL, with rst=1 at a clock edge, clear S1/S2 valid bits; out_valid=0, out_diff=0x00, out_borrow=0, out_zero=0.
REQ-025 SHALL drive in_ready=0 during the reset cycle and in_ready=1 in the first cycle after rst deasserts.
REQ-026 SHALL discard in-flight operations on reset mid-operation; no stale result appears after reset.
REQ-027 SHALL give rst priority over all handshakes in the same cycle.

Configuration
REQ-028 SHALL support macro KS_SUB8_SAT_EN: when defined, out_diff clamps to 0x00 whenever out_borrow=1 (out_zero then 1).
REQ-029 SHALL, without KS_SUB8_SAT_EN, output out_diff as wrap-around A-B mod 256; borrow, latency and handshake identical in both builds.

Verification
REQ-030 SHALL cover basic: A=0x5A, B=0x23, out_ready=1 -> 2 cycles later out_diff=0x37, borrow=0, zero=0.
REQ-031 SHALL cover underflow: A=0x10, B=0x20 -> out_diff=0xF0, borrow=1 (KS_SUB8_SAT_EN: 0x00, borrow=1, zero=1).
REQ-032 SHALL cover carry-propagate extremes: A=0x00,B=0x01 -> 0xFF,borrow=1; A=0xFF,B=0xFF -> 0x00,zero=1; A=0x80,B=0x7F -> 0x01.
REQ-033 SHALL cover back-to-back stream: 256 random pairs, out_ready=1 -> one result per cycle, all match model, in order.
REQ-034 SHALL cover stall: hold out_ready=0 for 5 cycles with in_valid=1 -> exactly 2 accepted, in_ready=0, outputs stable; release -> both emitted in order, acceptance resumes.
REQ-035 SHALL cover reset mid-stream: assert rst with both stages full -> next cycle out_valid=0, in_ready=0; after release no stale result emitted.
